// File: rtl/lab4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lab4_pkg : shared types and constants for the flash sample streamer.      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
package lab4_pkg;

  localparam int FLASH_ADDR_W = 23;
  localparam int FLASH_DATA_W = 32;
  localparam int SAMPLE_W     = 16;

  localparam logic [6:0] BURST_ONE = 7'd1;
  localparam logic [3:0] BE_ALL    = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_SEND_LO   = 3'd3,
    ST_SEND_HI   = 3'd4,
    ST_DONE      = 3'd5
  } streamer_state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] hi;
    logic [SAMPLE_W-1:0] lo;
  } sample_pair_t;

  function automatic sample_pair_t split_word(input logic [FLASH_DATA_W-1:0] word);
    sample_pair_t p;
    p.hi = word[31:16];
    p.lo = word[15:0];
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_sample_sender.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_sample_sender : attenuates one sample and drives the codec write.   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module audio_sample_sender
  import lab4_pkg::*;
#(
  parameter int SHIFT = 6
) (
  input  logic                valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                write_ready,
  output logic                write,
  output logic [SAMPLE_W-1:0] writedata_left,
  output logic [SAMPLE_W-1:0] writedata_right,
  output logic                accepted
);

  logic signed [SAMPLE_W-1:0] shifted;

  // Arithmetic shift floors toward negative infinity for negative samples.
  assign shifted         = $signed(sample) >>> SHIFT;
  assign write           = valid;
  assign writedata_left  = valid ? shifted : '0;
  assign writedata_right = valid ? shifted : '0;
  assign accepted        = valid & write_ready;

endmodule
`default_nettype wire

// File: rtl/flash_sample_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flash_sample_streamer : reads flash words and streams their two samples   |
// | to the audio codec. LOOP_PLAYBACK_EN makes playback wrap forever.         |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module flash_sample_streamer
  import lab4_pkg::*;
#(
  parameter int NUM_WORDS = 1048576,
  parameter int SHIFT     = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    flash_mem_read,
  output logic [FLASH_ADDR_W-1:0] flash_mem_address,
  input  logic                    flash_mem_waitrequest,
  input  logic [FLASH_DATA_W-1:0] flash_mem_readdata,
  input  logic                    flash_mem_readdatavalid,
  output logic [6:0]              flash_mem_burstcount,
  output logic                    flash_mem_write,
  output logic [3:0]              flash_mem_byteenable,
  output logic [FLASH_DATA_W-1:0] flash_mem_writedata,
  input  logic                    audio_write_ready,
  output logic                    audio_write,
  output logic [SAMPLE_W-1:0]     writedata_left,
  output logic [SAMPLE_W-1:0]     writedata_right
);

`ifdef LOOP_PLAYBACK_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [FLASH_ADDR_W-1:0] LAST_ADDR = FLASH_ADDR_W'(NUM_WORDS - 1);

  streamer_state_t         state, state_next;
  logic [FLASH_ADDR_W-1:0] addr;
  logic [SAMPLE_W-1:0]     lo_sample, hi_sample;
  logic [SAMPLE_W-1:0]     send_sample;
  logic                    send_valid;
  logic                    sample_accepted;
  logic                    start_ok;
  logic                    last_word;
  sample_pair_t            pair;

  assign pair      = split_word(flash_mem_readdata);
  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
  assign last_word = (addr == LAST_ADDR);

  assign flash_mem_address    = addr;
  assign flash_mem_burstcount = BURST_ONE;
  assign flash_mem_write      = 1'b0;
  assign flash_mem_byteenable = BE_ALL;
  assign flash_mem_writedata  = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (start) state_next = ST_REQ;
      ST_REQ:       if (!flash_mem_waitrequest) state_next = ST_WAIT_DATA;
      ST_WAIT_DATA: if (flash_mem_readdatavalid) state_next = ST_SEND_LO;
      ST_SEND_LO:   if (sample_accepted) state_next = ST_SEND_HI;
      ST_SEND_HI: begin
        if (sample_accepted) begin
          state_next = (last_word && !LOOP_EN) ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE:      if (start) state_next = ST_REQ;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    flash_mem_read = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    send_valid     = 1'b0;
    send_sample    = lo_sample;
    case (state)
      ST_REQ: begin
        flash_mem_read = 1'b1;
        busy           = 1'b1;
      end
      ST_WAIT_DATA: busy = 1'b1;
      ST_SEND_LO: begin
        busy       = 1'b1;
        send_valid = 1'b1;
      end
      ST_SEND_HI: begin
        busy        = 1'b1;
        send_valid  = 1'b1;
        send_sample = hi_sample;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Wrapping to zero after the last word serves both the loop build and the
  // next replay after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      lo_sample <= '0;
      hi_sample <= '0;
    end else begin
      if (start_ok) begin
        addr <= '0;
      end else if (state == ST_SEND_HI && sample_accepted) begin
        addr <= last_word ? '0 : addr + 1'b1;
      end
      if (state == ST_WAIT_DATA && flash_mem_readdatavalid) begin
        lo_sample <= pair.lo;
        hi_sample <= pair.hi;
      end
    end
  end

  audio_sample_sender #(
    .SHIFT(SHIFT)
  ) u_sender (
    .valid          (send_valid),
    .sample         (send_sample),
    .write_ready    (audio_write_ready),
    .write          (audio_write),
    .writedata_left (writedata_left),
    .writedata_right(writedata_right),
    .accepted       (sample_accepted)
  );

endmodule
`default_nettype wire

// File: tb/tb_flash_sample_streamer.sv
`default_nettype none
// Scoreboard bench: the flash model queues hand-computed samples as each word
// is returned, and a monitor pops them as the codec accepts writes.
`timescale 1ns/1ps
module tb_flash_sample_streamer;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic        flash_mem_waitrequest = 1'b0;
  logic [31:0] flash_mem_readdata = '0;
  logic        flash_mem_readdatavalid = 1'b0;
  logic [6:0]  flash_mem_burstcount;
  logic        flash_mem_write;
  logic [3:0]  flash_mem_byteenable;
  logic [31:0] flash_mem_writedata;
  logic        audio_write_ready = 1'b1;
  logic        audio_write;
  logic [15:0] writedata_left, writedata_right;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  int reads  = 0;
  int stall_cycles = 1;
  int exp_addr = 0;
  bit drop_next = 1'b0;

  logic [31:0] mem    [NW] = '{32'hC6C8E364, 32'h7FFF8000, 32'h0040FFFF, 32'h003FFFC0};
  logic [15:0] exp_lo [NW] = '{16'hFF8D, 16'hFE00, 16'hFFFF, 16'hFFFF};
  logic [15:0] exp_hi [NW] = '{16'hFF1B, 16'h01FF, 16'h0001, 16'h0000};
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  flash_sample_streamer #(.NUM_WORDS(NW), .SHIFT(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .flash_mem_read(flash_mem_read), .flash_mem_address(flash_mem_address),
    .flash_mem_waitrequest(flash_mem_waitrequest), .flash_mem_readdata(flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid), .flash_mem_burstcount(flash_mem_burstcount),
    .flash_mem_write(flash_mem_write), .flash_mem_byteenable(flash_mem_byteenable),
    .flash_mem_writedata(flash_mem_writedata), .audio_write_ready(audio_write_ready),
    .audio_write(audio_write), .writedata_left(writedata_left), .writedata_right(writedata_right)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Flash model: stall_cycles of waitrequest per request, data two cycles later.
  initial begin
    bit in_req = 1'b0;
    int wait_left = 0;
    int lat = 0;
    int pend = 0;
    logic [22:0] hold_addr = '0;
    forever begin
      @(negedge clk);
      flash_mem_readdatavalid = 1'b0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          flash_mem_readdatavalid = 1'b1;
          flash_mem_readdata = mem[pend];
          if (drop_next) drop_next = 1'b0;
          else begin
            exp_q.push_back(exp_lo[pend]);
            exp_q.push_back(exp_hi[pend]);
          end
        end
      end
      if (!rst_n) begin
        in_req = 1'b0;
        flash_mem_waitrequest = 1'b0;
      end else begin
        if (in_req) begin
          chk("read_held", {31'd0, flash_mem_read}, 32'd1);
          chk("addr_held", {9'd0, flash_mem_address}, {9'd0, hold_addr});
        end else if (flash_mem_read) begin
          in_req = 1'b1;
          hold_addr = flash_mem_address;
          wait_left = stall_cycles;
          chk("req_addr", {9'd0, flash_mem_address}, exp_addr);
          exp_addr = (exp_addr + 1) % NW;
        end
        if (in_req) begin
          if (wait_left > 0) begin
            flash_mem_waitrequest = 1'b1;
            wait_left--;
          end else begin
            flash_mem_waitrequest = 1'b0;
            in_req = 1'b0;
            pend = int'(hold_addr);
            lat = 2;
            reads++;
          end
        end else begin
          flash_mem_waitrequest = 1'b0;
        end
      end
    end
  end

  // Monitor: every presented sample must match the queue head until accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (audio_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h required=none", writedata_left);
        end else begin
          chk("left", {16'd0, writedata_left}, {16'd0, exp_q[0]});
          chk("right", {16'd0, writedata_right}, {16'd0, exp_q[0]});
          if (audio_write_ready) begin
            void'(exp_q.pop_front());
            writes++;
          end
        end
        chk("no_overlap", {31'd0, flash_mem_read}, 32'd0);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("read_after_start", {31'd0, flash_mem_read}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk("done_reached", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    chk("write_count", writes, 2 * NW);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_read"}, {31'd0, flash_mem_read}, 32'd0);
    chk({tag, "_addr"}, {9'd0, flash_mem_address}, 32'd0);
    chk({tag, "_awrite"}, {31'd0, audio_write}, 32'd0);
    chk({tag, "_wdata"}, {writedata_left, writedata_right}, 32'd0);
    chk({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    chk("burstcount", {25'd0, flash_mem_burstcount}, 32'd1);
    chk("const_write", {31'd0, flash_mem_write}, 32'd0);
    chk("byteenable", {28'd0, flash_mem_byteenable}, 32'hF);
    chk("writedata", flash_mem_writedata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

`ifdef LOOP_PLAYBACK_EN
    exp_addr = 0;
    pulse_start();
    for (int i = 0; i < 600 && writes < 6 * NW; i++) begin
      @(negedge clk);
      chk("loop_done_low", {31'd0, done}, 32'd0);
    end
    chk("loop_writes", {31'd0, writes >= 6 * NW}, 32'd1);
    chk("loop_busy", {31'd0, busy}, 32'd1);
`else
    // Full playback, one waitrequest cycle per read, codec always ready.
    exp_addr = 0;
    writes = 0;
    reads = 0;
    pulse_start();
    wait_done(300);
    chk("read_count", reads, NW);

    // Replay from word 0 with long flash stalls and a codec stall on SEND_LO.
    stall_cycles = 5;
    exp_addr = 0;
    writes = 0;
    reads = 0;
    @(posedge clk); #1;
    audio_write_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 100 && !audio_write; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("write_held", {31'd0, audio_write}, 32'd1);
      @(negedge clk);
    end
    chk("stall_no_count", writes, 0);
    @(posedge clk); #1;
    audio_write_ready = 1'b1;
    wait_done(400);
    chk("read_count2", reads, NW);

    // Reset while waiting for data: the late readdatavalid must be ignored.
    stall_cycles = 1;
    exp_addr = 0;
    writes = 0;
    pulse_start();
    for (int i = 0; i < 50 && flash_mem_read; i++) @(negedge clk);
    chk("in_wait_data", {31'd0, flash_mem_read}, 32'd0);
    drop_next = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (4) @(negedge clk);
    chk("late_rdv_seen", {31'd0, drop_next}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("idle_after_reset");
    exp_addr = 0;
    writes = 0;
    pulse_start();
    wait_done(300);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_sample_streamer.md
Name: flash_sample_streamer

Overview:
Downstream playback stage for the flash sample data. It walks flash word addresses 0..NUM_WORDS-1 over the Avalon-MM flash read interface. Each 32-bit word is split into two signed 16-bit samples, low half first. Each sample is attenuated by an arithmetic right shift and pushed, one per handshake, to the audio codec write port on both left and right channels.

Parameters:
NUM_WORDS, 1048576, number of 32-bit flash words to play (2*NUM_WORDS samples)
SHIFT, 6, arithmetic right-shift applied to each sample (volume attenuation)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins playback from word 0 when idle
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  high while in DONE; cleared by the next accepted start
flash_mem_read  out  1  Avalon read request
flash_mem_address  out  23  flash word address
flash_mem_waitrequest  in  1  Avalon stall
flash_mem_readdata  in  32  returned word
flash_mem_readdatavalid  in  1  returned word valid
flash_mem_burstcount  out  7  constant 7'd1
flash_mem_write  out  1  constant 0
flash_mem_byteenable  out  4  constant 4'hF
flash_mem_writedata  out  32  constant 0
audio_write_ready  in  1  codec FIFO can accept a sample
audio_write  out  1  sample write strobe
writedata_left  out  16  left sample
writedata_right  out  16  right sample (always equals left)

Behaviour:
- Reset, asynchronous: state IDLE; flash_mem_read=0, flash_mem_address=0, audio_write=0, writedata_*=0, busy=0, done=0. The word counter is cleared. Any in-flight flash read is abandoned, and a late readdatavalid is ignored because the block is in IDLE.
- States: IDLE, REQ, WAIT_DATA, SEND_LO, SEND_HI, DONE.
- IDLE: start=1 moves to REQ on the next edge. flash_mem_read rises in the cycle after start. start is ignored in every other state except DONE.
- REQ: flash_mem_read=1 with the current address.
  - While flash_mem_waitrequest=1, read and address are held stable.
  - In the first cycle with waitrequest=0, the request is accepted: read drops on the next edge and the state moves to WAIT_DATA.
- WAIT_DATA: waits any number of cycles for readdatavalid=1. On that edge:
  - readdata[15:0] and readdata[31:16] are latched;
  - the state moves to SEND_LO.
  readdatavalid outside WAIT_DATA is ignored.
- SEND_LO / SEND_HI:
  - writedata_left = writedata_right = sample >>> SHIFT, using signed arithmetic (sign-extended, floors toward negative).
  - audio_write=1 while in the state.
  - The transfer completes on the first edge where audio_write && audio_write_ready. audio_write drops on the next edge, or stays high when going straight into SEND_HI.
  - Exactly one transfer per sample; data is stable while audio_write=1 and ready=0.
  - SEND_LO always goes to SEND_HI.
  - SEND_HI goes to REQ with address+1, or to DONE when address == NUM_WORDS-1.
- DONE: done=1, busy=0, outputs idle. start=1 clears done and re-enters REQ at address 0.
- Throughput bound: at least 4 cycles per word with zero flash and codec stalls. Flash and audio never overlap.
- Address is a 23-bit counter; no wrap beyond NUM_WORDS-1 in the default build.

Optional Feature:
Macro LOOP_PLAYBACK_EN.
- Defined: after the last word's SEND_HI, the address wraps to 0 and the state returns to REQ. done never asserts; busy stays 1 until reset.
- Undefined: behaviour exactly as above, stopping in DONE.

Decomposition:
- Shared package lab4_pkg holds:
  - streamer state enum;
  - FLASH_ADDR_W=23, FLASH_DATA_W=32, SAMPLE_W=16;
  - Avalon constants (BURST_ONE=7'd1, BE_ALL=4'hF);
  - a function splitting a 32-bit word into {hi, lo} signed samples.
- Sub-module audio_sample_sender:
  - owns the write/write_ready handshake and the shift for a single sample;
  - has inputs valid and sample, and a one-cycle output accepted.

Test Plan:
- Reset then start, flash model with 1-cycle waitrequest and 2-cycle latency, word0=32'hC6C8E364, SHIFT=6, ready tied 1 -> audio writes 16'hFF8D then 16'hFF1B on both channels; flash_mem_address steps 0→1.
- Hold waitrequest=1 for 5 cycles -> flash_mem_read and address unchanged throughout; exactly one readdata consumed.
- audio_write_ready low for 10 cycles during SEND_LO -> audio_write held, data stable, exactly one sample counted per transfer.
- NUM_WORDS=4, words 0..3 -> 8 writes in order lo/hi per word; done=1, busy=0; a second start replays from address 0.
- Assert rst_n=0 in WAIT_DATA, then pulse readdatavalid -> all outputs at reset values, no audio_write; a later start resumes from address 0.
- With LOOP_PLAYBACK_EN and NUM_WORDS=2 -> address sequence 0,1,0,1…; done stays 0 across ≥3 loops.
